// File: rtl/rx_iq_serializer.sv
// rx_iq_serializer
//   Serializes one I/Q sample set per spd_rdy rising edge into a byte-wide
//   FIFO write stream. The base receiver (Rx_number) is always sent first,
//   followed by every other receiver enabled in Sync, in ascending order with
//   wrap-around. Each receiver contributes its I word then its Q word, both
//   MSB-first.
//
// Ports
//   clock, reset         single clock, synchronous active-high reset
//   Rx_number            base receiver index (values >= NR fall back to 0)
//   Sync_data_in_I/Q     flattened sample words, receiver k at [k*IQ_WIDTH +: IQ_WIDTH]
//   spd_rdy              new sample set valid (rising edge starts a set)
//   fifo_full/afull      downstream FIFO status
//   Sync                 mask of extra receivers to send
//   wrenable, data_out   FIFO write strobe and byte
//   fifo_clear           one-cycle FIFO flush pulse
//   frame_start          marks the first byte of a set
//   overrun_cnt          saturating count of dropped sets
module rx_iq_serializer #(
  parameter int NR       = 8,
  parameter int IQ_WIDTH = 24
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [$clog2(NR)-1:0]    Rx_number,
  input  logic [NR*IQ_WIDTH-1:0]   Sync_data_in_I,
  input  logic [NR*IQ_WIDTH-1:0]   Sync_data_in_Q,
  input  logic                     spd_rdy,
  input  logic                     fifo_full,
  input  logic                     fifo_afull,
  input  logic [NR-1:0]            Sync,
  output logic                     wrenable,
  output logic [7:0]               data_out,
  output logic                     fifo_clear,
  output logic                     frame_start,
  output logic [15:0]              overrun_cnt
);

  localparam int BYTES = IQ_WIDTH / 8;
  localparam int NB    = 2 * BYTES;       // bytes per receiver
  localparam int RW    = $clog2(NR);
  localparam int PW    = $clog2(NB);

  typedef enum logic [2:0] {CLEAR, WAIT, LOAD, SEND, NEXT, DONE, FLUSH} state_t;

  state_t              state_reg, state_next;
  logic                spd_rdy_d_reg;
  logic [NR-1:0]       active_mask_reg, active_mask_next;
  logic [RW-1:0]       base_reg, base_next;
  logic [NR-1:0]       sync_cfg_reg, sync_cfg_next;
  logic [RW-1:0]       rx_cfg_reg, rx_cfg_next;
  logic [RW-1:0]       cur_reg, cur_next;
  logic [PW-1:0]       ptr_reg, ptr_next;
  logic                pending_reg, pending_next;
  logic                wrenable_next, fifo_clear_next, frame_start_next;
  logic [7:0]          data_out_next;
  logic [15:0]         overrun_next;
  logic                load_shadow;

  logic [IQ_WIDTH-1:0] in_i [NR];
  logic [IQ_WIDTH-1:0] in_q [NR];
  logic [IQ_WIDTH-1:0] shadow_i [NR];
  logic [IQ_WIDTH-1:0] shadow_q [NR];

  logic [2*IQ_WIDTH-1:0] pair_word;
  logic [7:0]            pair_bytes [NB];
  logic [7:0]            cur_byte;

  logic [RW-1:0]       cand_idx [NR-1];
  logic [NR-2:0]       cand_hit;
  logic [RW-1:0]       next_idx;

  logic                spd_rise;
  logic                cfg_changed;
  logic [RW-1:0]       base_eff;

  assign spd_rise    = spd_rdy & ~spd_rdy_d_reg;
  assign cfg_changed = (Sync != sync_cfg_reg) || (Rx_number != rx_cfg_reg);
  assign base_eff    = (int'(Rx_number) < NR) ? Rx_number : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NR; gi++) begin : g_unpack
      assign in_i[gi] = Sync_data_in_I[gi*IQ_WIDTH +: IQ_WIDTH];
      assign in_q[gi] = Sync_data_in_Q[gi*IQ_WIDTH +: IQ_WIDTH];
    end

    // pair_bytes[0] is the MSB of I, pair_bytes[NB-1] the LSB of Q.
    for (gi = 0; gi < NB; gi++) begin : g_bytes
      assign pair_bytes[gi] = pair_word[(NB-1-gi)*8 +: 8];
    end

    // Candidate receivers after cur, in wrap order (cur+1, cur+2, ...).
    for (gi = 0; gi < NR-1; gi++) begin : g_cand
      assign cand_idx[gi] = RW'((int'(cur_reg) + gi + 1) % NR);
      assign cand_hit[gi] = active_mask_reg[cand_idx[gi]];
    end
  endgenerate

  assign pair_word = {shadow_i[cur_reg], shadow_q[cur_reg]};
  assign cur_byte  = pair_bytes[ptr_reg];

  // First enabled receiver after cur. The base bit is always set, so the
  // search reaches base at the latest; finding base means the set is done.
  always_comb begin
    next_idx = base_reg;
    for (int j = NR-2; j >= 0; j--) begin
      if (cand_hit[j]) next_idx = cand_idx[j];
    end
  end

  always_comb begin
    state_next       = state_reg;
    active_mask_next = active_mask_reg;
    base_next        = base_reg;
    sync_cfg_next    = sync_cfg_reg;
    rx_cfg_next      = rx_cfg_reg;
    cur_next         = cur_reg;
    ptr_next         = ptr_reg;
    pending_next     = pending_reg;
    wrenable_next    = 1'b0;
    frame_start_next = 1'b0;
    fifo_clear_next  = 1'b0;
    data_out_next    = data_out;
    overrun_next     = overrun_cnt;
    load_shadow      = 1'b0;

    case (state_reg)
      CLEAR: begin
        active_mask_next = Sync | (NR'(1) << base_eff);
        base_next        = base_eff;
        sync_cfg_next    = Sync;
        rx_cfg_next      = Rx_number;
        pending_next     = 1'b0;
        state_next       = WAIT;
      end
      WAIT: begin
        if (fifo_full || cfg_changed) state_next = FLUSH;
        else if (spd_rise)            state_next = LOAD;
      end
      LOAD: begin
        load_shadow = 1'b1;
        cur_next    = base_reg;
        ptr_next    = '0;
        state_next  = SEND;
      end
      SEND: begin
        // Almost-full stalls with the byte pointer held.
        if (!fifo_afull) begin
          wrenable_next    = 1'b1;
          data_out_next    = cur_byte;
          frame_start_next = (cur_reg == base_reg) && (ptr_reg == '0);
          if (ptr_reg == PW'(NB-1)) begin
            ptr_next   = '0;
            state_next = NEXT;
          end else begin
            ptr_next = ptr_reg + 1'b1;
          end
        end
      end
      NEXT: begin
        if (next_idx == base_reg) begin
          state_next = DONE;
        end else begin
          cur_next   = next_idx;
          state_next = SEND;
        end
      end
      DONE: begin
        if (!spd_rdy) state_next = (pending_reg || cfg_changed) ? FLUSH : CLEAR;
      end
      FLUSH: begin
        fifo_clear_next = 1'b1;
        state_next      = CLEAR;
      end
      default: state_next = CLEAR;
    endcase

    // While a set is in flight, configuration changes are deferred, and a
    // new sample set drops the current one. A dropped set leaves a partial
    // frame in the FIFO, so it is also flushed on the way out.
    if (state_reg == LOAD || state_reg == SEND || state_reg == NEXT) begin
      if (cfg_changed) pending_next = 1'b1;
      if (spd_rise) begin
        if (overrun_cnt != 16'hFFFF) overrun_next = overrun_cnt + 16'd1;
        pending_next     = 1'b1;
        wrenable_next    = 1'b0;
        frame_start_next = 1'b0;
        state_next       = DONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= CLEAR;
      spd_rdy_d_reg   <= 1'b0;
      active_mask_reg <= '0;
      base_reg        <= '0;
      sync_cfg_reg    <= '0;
      rx_cfg_reg      <= '0;
      cur_reg         <= '0;
      ptr_reg         <= '0;
      pending_reg     <= 1'b0;
      wrenable        <= 1'b0;
      data_out        <= 8'h00;
      fifo_clear      <= 1'b0;
      frame_start     <= 1'b0;
      overrun_cnt     <= 16'h0000;
      for (int k = 0; k < NR; k++) begin
        shadow_i[k] <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      state_reg       <= state_next;
      spd_rdy_d_reg   <= spd_rdy;
      active_mask_reg <= active_mask_next;
      base_reg        <= base_next;
      sync_cfg_reg    <= sync_cfg_next;
      rx_cfg_reg      <= rx_cfg_next;
      cur_reg         <= cur_next;
      ptr_reg         <= ptr_next;
      pending_reg     <= pending_next;
      wrenable        <= wrenable_next;
      data_out        <= data_out_next;
      fifo_clear      <= fifo_clear_next;
      frame_start     <= frame_start_next;
      overrun_cnt     <= overrun_next;
      if (load_shadow) begin
        for (int k = 0; k < NR; k++) begin
          shadow_i[k] <= in_i[k];
          shadow_q[k] <= in_q[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_iq_serializer.sv
module tb_rx_iq_serializer;

  localparam int NR = 8;
  localparam int IQ = 24;

  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spd = 1'b0, full = 1'b0, afull = 1'b0;

  // 24-bit, 8-receiver instance
  logic [2:0]         rx;
  logic [NR*IQ-1:0]   di, dq;
  logic [7:0]         sync;
  logic               wr, fs, clr;
  logic [7:0]         dout;
  logic [15:0]        ovr;

  // 16-bit and 32-bit, 4-receiver instances
  logic [1:0]   rx16, rx32;
  logic [63:0]  di16, dq16;
  logic [127:0] di32, dq32;
  logic [3:0]   sync16, sync32;
  logic         wr16, fs16, clr16, wr32, fs32, clr32;
  logic [7:0]   dout16, dout32;
  logic [15:0]  ovr16, ovr32;

  int total = 0;
  int bad   = 0;
  int clr_cnt = 0;
  int lat;
  int low;
  int ones;

  logic [7:0] q24 [$];
  bit         fsq [$];
  logic [7:0] q16 [$];
  logic [7:0] q32 [$];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  rx_iq_serializer #(.NR(NR), .IQ_WIDTH(IQ)) dut (
    .clock(clk), .reset(rst), .Rx_number(rx),
    .Sync_data_in_I(di), .Sync_data_in_Q(dq),
    .spd_rdy(spd), .fifo_full(full), .fifo_afull(afull), .Sync(sync),
    .wrenable(wr), .data_out(dout), .fifo_clear(clr),
    .frame_start(fs), .overrun_cnt(ovr)
  );

  rx_iq_serializer #(.NR(4), .IQ_WIDTH(16)) dut16 (
    .clock(clk), .reset(rst), .Rx_number(rx16),
    .Sync_data_in_I(di16), .Sync_data_in_Q(dq16),
    .spd_rdy(spd), .fifo_full(full), .fifo_afull(afull), .Sync(sync16),
    .wrenable(wr16), .data_out(dout16), .fifo_clear(clr16),
    .frame_start(fs16), .overrun_cnt(ovr16)
  );

  rx_iq_serializer #(.NR(4), .IQ_WIDTH(32)) dut32 (
    .clock(clk), .reset(rst), .Rx_number(rx32),
    .Sync_data_in_I(di32), .Sync_data_in_Q(dq32),
    .spd_rdy(spd), .fifo_full(full), .fifo_afull(afull), .Sync(sync32),
    .wrenable(wr32), .data_out(dout32), .fifo_clear(clr32),
    .frame_start(fs32), .overrun_cnt(ovr32)
  );

  // Byte collectors, sampled mid-cycle
  always @(negedge clk) begin
    if (wr) begin
      q24.push_back(dout);
      fsq.push_back(fs);
    end
    if (clr)  clr_cnt++;
    if (wr16) q16.push_back(dout16);
    if (wr32) q32.push_back(dout32);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end else begin
      $display("check %s got=%0h ok", tag, got);
    end
  endtask

  task automatic check_q(input string tag, input bq_t act);
    chk({tag, "_len"}, act.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), act[i], exp_q[i]);
  endtask

  // Pattern data: receiver k's I bytes are k1 k2 k3, Q bytes k4 k5 k6 (hex).
  task automatic fill_pattern();
    for (int k = 0; k < NR; k++) begin
      di[k*IQ +: IQ] = {8'(k*16+1), 8'(k*16+2), 8'(k*16+3)};
      dq[k*IQ +: IQ] = {8'(k*16+4), 8'(k*16+5), 8'(k*16+6)};
    end
  endtask

  task automatic add_rx(input int k);
    for (int j = 1; j <= 6; j++) exp_q.push_back(8'(k*16+j));
  endtask

  // Raise spd_rdy at a falling edge and return the number of cycles until the
  // 24-bit instance shows its first write strobe; spd_rdy is then lowered.
  task automatic start_set(output int l);
    spd = 1'b1;
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!wr && l < 40);
    spd = 1'b0;
  endtask

  task automatic count_fs();
    ones = 0;
    foreach (fsq[i]) if (fsq[i]) ones++;
  endtask

  initial begin
    rx = 3'd2; sync = 8'h00;
    rx16 = 2'd1; sync16 = 4'h0;
    rx32 = 2'd3; sync32 = 4'h0;
    di = '0; dq = '0; di16 = '0; dq16 = '0; di32 = '0; dq32 = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_wr", wr, 1'b0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_clr", clr, 1'b0);
    chk("rst_fs", fs, 1'b0);
    chk("rst_ovr", ovr, 16'h0000);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single receiver, known words, latency and frame marker
    fill_pattern();
    di[2*IQ +: IQ] = 24'hABCDEF;
    dq[2*IQ +: IQ] = 24'h123456;
    q24.delete(); fsq.delete();
    start_set(lat);
    chk("latency", lat, 3);
    di[2*IQ +: IQ] = 24'h000000;   // must not affect the bytes in flight
    repeat (30) @(negedge clk);
    exp_q = '{8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34, 8'h56};
    check_q("single", q24);
    count_fs();
    chk("single_fs_first", fsq.size() > 0 ? fsq[0] : 1'b0, 1'b1);
    chk("single_fs_count", ones, 1);
    repeat (20) @(negedge clk);
    chk("single_idle", q24.size(), 6);

    // Base 6, mask 0x83 -> order 6,7,0,1
    rx = 3'd6; sync = 8'h83;
    fill_pattern();
    repeat (10) @(negedge clk);
    q24.delete(); fsq.delete();
    start_set(lat);
    repeat (50) @(negedge clk);
    exp_q.delete();
    add_rx(6); add_rx(7); add_rx(0); add_rx(1);
    check_q("wrap", q24);
    count_fs();
    chk("wrap_fs_count", ones, 1);

    // Almost-full stall after the 2nd byte
    rx = 3'd2; sync = 8'h00;
    repeat (10) @(negedge clk);
    q24.delete(); fsq.delete();
    start_set(lat);
    @(negedge clk);
    chk("afull_b2_wr", wr, 1'b1);
    afull = 1'b1;
    low = 0;
    repeat (3) begin
      @(negedge clk);
      if (!wr) low++;
    end
    afull = 1'b0;
    chk("afull_low_cycles", low, 3);
    @(negedge clk);
    chk("afull_resume_wr", wr, 1'b1);
    repeat (20) @(negedge clk);
    exp_q.delete();
    add_rx(2);
    check_q("afull", q24);

    // Sync change mid-set: finish with old mask, flush once, then new mask
    rx = 3'd0; sync = 8'h02;
    repeat (10) @(negedge clk);
    clr_cnt = 0;
    q24.delete(); fsq.delete();
    start_set(lat);
    sync = 8'h04;
    repeat (40) @(negedge clk);
    exp_q.delete();
    add_rx(0); add_rx(1);
    check_q("midchg_old", q24);
    chk("midchg_clr", clr_cnt, 1);
    q24.delete(); fsq.delete();
    start_set(lat);
    repeat (40) @(negedge clk);
    exp_q.delete();
    add_rx(0); add_rx(2);
    check_q("midchg_new", q24);
    chk("midchg_clr_after", clr_cnt, 1);

    // fifo_full in WAIT gives one clear pulse
    rx = 3'd2; sync = 8'h00;
    repeat (10) @(negedge clk);
    clr_cnt = 0;
    full = 1'b1;
    @(negedge clk);
    full = 1'b0;
    repeat (10) @(negedge clk);
    chk("full_clr", clr_cnt, 1);

    // spd_rdy re-pulsed during SEND drops the set after 2 bytes
    q24.delete(); fsq.delete();
    start_set(lat);
    @(negedge clk);
    spd = 1'b1;
    @(negedge clk);
    spd = 1'b0;
    repeat (20) @(negedge clk);
    chk("overrun_cnt", ovr, 16'd1);
    chk("overrun_bytes", q24.size(), 2);

    // 16-bit and 32-bit sample widths
    di16[1*16 +: 16] = 16'hA1B2;
    dq16[1*16 +: 16] = 16'hC3D4;
    di32[3*32 +: 32] = 32'h01234567;
    dq32[3*32 +: 32] = 32'h89ABCDEF;
    repeat (10) @(negedge clk);
    q16.delete(); q32.delete(); q24.delete(); fsq.delete();
    start_set(lat);
    repeat (40) @(negedge clk);
    exp_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    check_q("w16", q16);
    exp_q = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    check_q("w32", q32);

    // Reset on the 3rd byte abandons the set
    q24.delete(); fsq.delete();
    start_set(lat);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_b3_wr", wr, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_wr", wr, 1'b0);
    chk("rstmid_dout", dout, 8'h00);
    chk("rstmid_ovr", ovr, 16'h0000);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rstmid_no_resume", q24.size(), 3);
    q24.delete(); fsq.delete();
    start_set(lat);
    repeat (20) @(negedge clk);
    exp_q.delete();
    add_rx(2);
    check_q("after_rst", q24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
